// File: rtl/register_file_clr_if.sv
// Register-file access bus: two combinational read ports, one write port,
// and the ready flag raised once the post-reset clear sweep has finished.
interface register_file_clr_if #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 5
);
    logic                  WE3;
    logic [ADDR_WIDTH-1:0] A1;
    logic [ADDR_WIDTH-1:0] A2;
    logic [ADDR_WIDTH-1:0] A3;
    logic [DATA_WIDTH-1:0] WD3;
    logic [DATA_WIDTH-1:0] RD1;
    logic [DATA_WIDTH-1:0] RD2;
    logic                  ready;

    // Requester side: issues addresses and write data, observes read data.
    modport master (
        output WE3, A1, A2, A3, WD3,
        input  RD1, RD2, ready
    );

    // Register-file side.
    modport slave (
        input  WE3, A1, A2, A3, WD3,
        output RD1, RD2, ready
    );
endinterface

// File: rtl/register_file_clr.sv
// Three-port register file (2 read, 1 write) that zeroes its contents with a
// one-register-per-clock sweep after reset instead of resetting the array.
// Ready rises on the edge that clears the last register.
// Optional feature: define REGISTER_FILE_CLR_BYPASS_EN to forward WD3 to a
// read port in the same cycle when it addresses the register being written.
module register_file_clr #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 5,
    parameter int ZERO_REG   = 1
) (
    input  logic                clk,
    input  logic                rst_n,
    register_file_clr_if.slave  bus
);
    localparam int                    NUM_REGS = 2 ** ADDR_WIDTH;
    localparam logic [ADDR_WIDTH-1:0] LAST_REG = ADDR_WIDTH'(NUM_REGS - 1);

    typedef enum logic {
        CLEAR = 1'b0,
        RUN   = 1'b1
    } state_t;

    state_t                state;
    state_t                state_nxt;
    logic [ADDR_WIDTH-1:0] cnt;
    logic [ADDR_WIDTH-1:0] cnt_nxt;
    logic                  ready_q;
    logic                  ready_nxt;
    logic                  wr_ok;
    logic [DATA_WIDTH-1:0] rd1;
    logic [DATA_WIDTH-1:0] rd2;

    // NOTE: the storage array has no reset; it is zeroed only by the sweep,
    // which keeps it mappable onto plain RAM/flop arrays without reset fan-out.
    logic [DATA_WIDTH-1:0] regs [NUM_REGS];

    // A port-3 write that actually lands: writes to a hardwired zero register
    // are dropped here so both the array and the forwarding path honour it.
    assign wr_ok = bus.WE3 && !((ZERO_REG != 0) && (bus.A3 == '0));

    // FSM state, sweep counter and ready flag; synchronous active-low reset.
    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignments for all clocked state, so every
        // register samples pre-edge values regardless of statement order.
        if (!rst_n) begin
            state   <= CLEAR;
            cnt     <= '0;
            ready_q <= 1'b0;
        end else begin
            state   <= state_nxt;
            cnt     <= cnt_nxt;
            ready_q <= ready_nxt;
        end
    end

    // Next-state logic: step the sweep, leave CLEAR on the last register and
    // then hold everything, since RUN is only left through reset.
    always_comb begin
        // NOTE: defaults first so no path through this block infers a latch.
        state_nxt = state;
        cnt_nxt   = cnt;
        ready_nxt = ready_q;
        if (state == CLEAR) begin
            if (cnt == LAST_REG) begin
                state_nxt = RUN;
                ready_nxt = 1'b1;
            end else begin
                cnt_nxt = cnt + 1'b1;
            end
        end
    end

    // Array update: sweep zeroes in CLEAR, port-3 writes only in RUN.
    always_ff @(posedge clk) begin
        if (rst_n) begin
            if (state == CLEAR) begin
                regs[cnt] <= '0;
            end else if (wr_ok) begin
                regs[bus.A3] <= bus.WD3;
            end
        end
    end

    // Combinational read ports; forced to zero while the sweep is running.
    always_comb begin
        rd1 = '0;
        rd2 = '0;
        if (state == RUN) begin
            rd1 = regs[bus.A1];
            rd2 = regs[bus.A2];
            if ((ZERO_REG != 0) && (bus.A1 == '0)) rd1 = '0;
            if ((ZERO_REG != 0) && (bus.A2 == '0)) rd2 = '0;
`ifdef REGISTER_FILE_CLR_BYPASS_EN
            if (wr_ok && (bus.A3 == bus.A1)) rd1 = bus.WD3;
            if (wr_ok && (bus.A3 == bus.A2)) rd2 = bus.WD3;
`endif
        end
    end

    assign bus.RD1   = rd1;
    assign bus.RD2   = rd2;
    assign bus.ready = ready_q;

endmodule

// File: tb/tb_register_file_clr.sv
// Scoreboard bench for register_file_clr: stimulus pushes expected values
// for two instances (ZERO_REG=1 and ZERO_REG=0, same inputs) and a monitor
// pops and compares them at each sample point.
`timescale 1ns/1ps
module tb_register_file_clr;
    localparam int DW = 32;
    localparam int AW = 5;

`ifdef REGISTER_FILE_CLR_BYPASS_EN
    localparam bit BYPASS = 1'b1;
`else
    localparam bit BYPASS = 1'b0;
`endif

    typedef struct {
        string           name;
        logic [DW-1:0]   rd1;
        logic [DW-1:0]   rd2;
        logic            rdy;
        logic [DW-1:0]   rd1b;
        logic [DW-1:0]   rd2b;
    } exp_t;

    logic clk;
    logic rst_n;
    int   n_checks;
    int   n_fail;
    exp_t sb_q[$];
    event sample_ev;

    register_file_clr_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus   ();
    register_file_clr_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus_b ();

    assign bus_b.WE3 = bus.WE3;
    assign bus_b.A1  = bus.A1;
    assign bus_b.A2  = bus.A2;
    assign bus_b.A3  = bus.A3;
    assign bus_b.WD3 = bus.WD3;

    register_file_clr #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .ZERO_REG(1)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    register_file_clr #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .ZERO_REG(0)) dut_b (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus_b.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, req);
        end
    endtask

    // Monitor: compare DUT outputs against the oldest scoreboard entry.
    initial begin
        exp_t e;
        forever begin
            @(sample_ev);
            if (sb_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL scoreboard_underflow: got empty queue, expected an entry");
            end else begin
                e = sb_q.pop_front();
                check({e.name, ".rd1"},    bus.RD1,            e.rd1);
                check({e.name, ".rd2"},    bus.RD2,            e.rd2);
                check({e.name, ".ready"},  DW'(bus.ready),     DW'(e.rdy));
                check({e.name, ".b.rd1"},  bus_b.RD1,          e.rd1b);
                check({e.name, ".b.rd2"},  bus_b.RD2,          e.rd2b);
                check({e.name, ".b.ready"}, DW'(bus_b.ready),  DW'(e.rdy));
            end
        end
    end

    task automatic expect2(input string name, input logic [DW-1:0] rd1, input logic [DW-1:0] rd2,
                           input logic rdy, input logic [DW-1:0] rd1b, input logic [DW-1:0] rd2b);
        exp_t e;
        e.name = name; e.rd1 = rd1; e.rd2 = rd2; e.rdy = rdy; e.rd1b = rd1b; e.rd2b = rd2b;
        sb_q.push_back(e);
        ->sample_ev;
        #0;
    endtask

    task automatic expect1(input string name, input logic [DW-1:0] rd1, input logic [DW-1:0] rd2,
                           input logic rdy);
        expect2(name, rd1, rd2, rdy, rd1, rd2);
    endtask

    // All tasks below are entered and left just after a falling edge.
    task automatic do_reset(input int cycles);
        rst_n   = 1'b0;
        bus.WE3 = 1'b0;
        repeat (cycles) @(posedge clk);
        #1 expect1("reset", '0, '0, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    // Clock n edges of a sweep; optionally attempt a write at edge wr_edge.
    task automatic run_edges(input int n, input int wr_edge);
        for (int e = 1; e <= n; e++) begin
            bus.A1  = AW'(e);
            bus.A2  = AW'(e + 16);
            bus.A3  = AW'(7);
            bus.WD3 = 32'hA5A5_A5A5;
            bus.WE3 = (e == wr_edge);
            @(posedge clk);
            #1 expect1($sformatf("sweep_e%0d", e), '0, '0, (e == 32));
            @(negedge clk);
        end
        bus.WE3 = 1'b0;
    endtask

    task automatic write_reg(input int addr, input logic [DW-1:0] data);
        bus.WE3 = 1'b1;
        bus.A3  = AW'(addr);
        bus.WD3 = data;
        @(negedge clk);
        bus.WE3 = 1'b0;
    endtask

    task automatic read_all_zero();
        for (int a = 0; a < 32; a++) begin
            bus.A1 = AW'(a);
            bus.A2 = AW'(31 - a);
            #1 expect1($sformatf("zero_a%0d", a), '0, '0, 1'b1);
            @(negedge clk);
        end
    endtask

    // Watchdog: the run must never hang.
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected end of test");
        $fatal(1, "timeout");
    end

    initial begin
        n_checks = 0;
        n_fail   = 0;
        rst_n    = 1'b0;
        bus.WE3  = 1'b0;
        bus.A1   = '0;
        bus.A2   = '0;
        bus.A3   = '0;
        bus.WD3  = '0;
        @(negedge clk);

        // Power-up: 2-cycle reset, full sweep with an ignored write at edge 3.
        do_reset(2);
        run_edges(32, 3);
        read_all_zero();

        // Write to reg 5 with both ports reading it.
        bus.A1 = AW'(5);
        bus.A2 = AW'(5);
        bus.WE3 = 1'b1; bus.A3 = AW'(5); bus.WD3 = 32'hDEAD_BEEF;
        #1 expect1("r5_pre", BYPASS ? 32'hDEAD_BEEF : 32'h0, BYPASS ? 32'hDEAD_BEEF : 32'h0, 1'b1);
        @(negedge clk);
        bus.WE3 = 1'b0;
        #1 expect1("r5_post", 32'hDEAD_BEEF, 32'hDEAD_BEEF, 1'b1);
        @(negedge clk);

        // Write to address 0: dropped when hardwired, stored otherwise.
        bus.A1 = AW'(0);
        bus.WE3 = 1'b1; bus.A3 = AW'(0); bus.WD3 = 32'h1234_5678;
        #1 expect2("r0_pre", 32'h0, 32'hDEAD_BEEF, 1'b1,
                   BYPASS ? 32'h1234_5678 : 32'h0, 32'hDEAD_BEEF);
        @(negedge clk);
        bus.WE3 = 1'b0;
        #1 expect2("r0_post", 32'h0, 32'hDEAD_BEEF, 1'b1, 32'h1234_5678, 32'hDEAD_BEEF);
        @(negedge clk);

        // Overwrite reg 9 while reading it: forwarding vs old value.
        write_reg(9, 32'h11);
        bus.A1 = AW'(9);
        bus.A2 = AW'(9);
        bus.WE3 = 1'b1; bus.A3 = AW'(9); bus.WD3 = 32'h22;
        #1 expect1("r9_pre", BYPASS ? 32'h22 : 32'h11, BYPASS ? 32'h22 : 32'h11, 1'b1);
        @(negedge clk);
        bus.WE3 = 1'b0;
        #1 expect1("r9_post", 32'h22, 32'h22, 1'b1);
        @(negedge clk);

        // Top register boundary.
        write_reg(31, 32'hCAFE_0031);
        bus.A1 = AW'(31);
        bus.A2 = AW'(0);
        #1 expect2("r31", 32'hCAFE_0031, 32'h0, 1'b1, 32'hCAFE_0031, 32'h1234_5678);
        @(negedge clk);

        // Reset in RUN, then again mid-sweep at edge 10, then a full sweep.
        bus.A1 = AW'(5);
        bus.A2 = AW'(9);
        do_reset(1);
        run_edges(10, 0);
        do_reset(1);
        run_edges(32, 0);
        read_all_zero();

        #1;
        if (sb_q.size() != 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL scoreboard_leftover: got %0d entries, expected 0", sb_q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
